fadd_pipe_n: RTL and testbench
==============================

# fadd_pipe_n

Pipelined, parametrised successor of the combinational dual-path floating-point adder in the FADD datapath. Accepts one add or subtract per cycle through a valid/ready handshake, aligns, adds and normalises over three registered stages, and returns a normalised truncated result with overflow/underflow flags and a pass-through tag. Sits between the operand issue logic and the result writeback of the FPU.

## Interface
Parameters:
- FRAC_WIDTH, 36, fraction width; normalised fraction has MSB = 1 (value = frac · 2^(exp−FRAC_WIDTH+1)), frac = 0 means zero
- EXP_WIDTH, 8, signed two's-complement exponent width
- TAG_WIDTH, 4, opaque tag carried alongside each operation

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  synchronous active-low reset
- i_valid  in  1  operand pair valid
- o_ready  out  1  block can accept this cycle
- i_op  in  1  0 = A+B, 1 = A−B (sign of B inverted)
- i_sign_a, i_sign_b  in  1  operand signs
- i_exp_a, i_exp_b  in  EXP_WIDTH  signed exponents
- i_frac_a, i_frac_b  in  FRAC_WIDTH  fractions
- i_tag  in  TAG_WIDTH  tag
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_sign_c  out  1  result sign
- o_exp_c  out  EXP_WIDTH  signed result exponent
- o_frac_c  out  FRAC_WIDTH  normalised result fraction
- o_ovf, o_unf  out  1  exponent overflow / underflow flags
- o_tag  out  TAG_WIDTH  tag of the result

## Operation
- Zero operand: frac = 0; its sign/exp are ignored for alignment; result equals the other operand (with op applied). Both zero → +0.
- S1 (align): effective sign_b = i_sign_b ^ i_op. Compare exponents as EXP_WIDTH+1-bit signed difference; swap so the large operand has the larger exponent (equal exponents: larger fraction is large). Right-shift the small fraction into FRAC_WIDTH+2 bits (two guard bits); shift ≥ FRAC_WIDTH+2 yields 0. Register sign_l, exp_l, aligned fractions, sub = sign_a ^ sign_b_eff.
- S2 (add): FRAC_WIDTH+3-bit sum (sub ? large − small : large + small); the result is never negative due to the swap. Result sign = sign of the large operand.
- S3 (normalise): carry-out → shift right 1, exp+1; otherwise leading-zero count n, shift left n, exp−n. Truncate guard bits (round toward zero). Exponent is computed in EXP_WIDTH+2 bits before range check.
- Exact zero sum → sign 0, exp 0, frac 0, no flags.
- Exponent > 2^(EXP_WIDTH−1)−1 → o_ovf = 1, exp = max, frac all ones, sign kept.
- Exponent < −2^(EXP_WIDTH−1) → o_unf = 1, flush to +0 (exp 0, frac 0).
- Tag travels unmodified with its operation.

## Timing
- Latency 3 cycles: operation accepted at edge t (i_valid & o_ready) is presented on o_valid after edge t+3 when no stall occurs.
- Throughput 1/cycle. Global stall: stall = o_valid & ~i_ready; o_ready = ~stall. During stall every stage register holds; inputs are ignored.
- Bubbles are not collapsed; a stage's valid bit moves with its data.
- o_valid and data are stable while o_valid & ~i_ready.
- Reset (i_rst_n = 0 at edge): all stage valids 0, o_valid 0, all outputs 0, o_ready 1 from the following cycle; in-flight operations are discarded, including mid-stall.
- i_valid with o_ready = 0 is not accepted; the source must hold.

## Test plan
- 1.0 + 1.0 (frac 36'h8_0000_0000, exp 0 both, op 0) -> 3 cycles later o_valid = 1, sign 0, exp 1, frac 36'h8_0000_0000, flags 0.
- 1.5 − 1.0 (frac_a 36'hC_0000_0000, frac_b 36'h8_0000_0000, exp 0, op 1) -> sign 0, exp −1, frac 36'h8_0000_0000; 1.0 − 1.0 -> +0, exp 0, frac 0.
- exp_a 0 frac 1.0 plus exp_b −40 frac 1.0 -> result exactly 1.0 (truncated); exp_a 127 + exp_b 127, fracs 1.0 -> o_ovf = 1, exp 127, frac all ones.
- exp −128 1.5 − exp −128 1.0 -> exponent −129, o_unf = 1, result +0.
- Back-to-back 8 ops with tags 0..7, i_ready held low cycles 5–7 -> o_ready low while stalled, outputs stable, all 8 results emerge in order with correct tags, none lost or duplicated.
- Assert i_rst_n = 0 for one cycle with 3 ops in flight -> o_valid 0 and outputs 0 next cycle, no in-flight result ever appears, new op accepted afterwards completes in 3 cycles.

Source files
------------

// File: rtl/fadd_pipe_n.sv
// rtl/fadd_pipe_n.sv - pipelined floating-point add/subtract with valid/ready handshake
module fadd_pipe_n #(
    parameter int FRAC_WIDTH = 36,
    parameter int EXP_WIDTH  = 8,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_op,
    input  logic                  i_sign_a,
    input  logic                  i_sign_b,
    input  logic [EXP_WIDTH-1:0]  i_exp_a,
    input  logic [EXP_WIDTH-1:0]  i_exp_b,
    input  logic [FRAC_WIDTH-1:0] i_frac_a,
    input  logic [FRAC_WIDTH-1:0] i_frac_b,
    input  logic [TAG_WIDTH-1:0]  i_tag,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_sign_c,
    output logic [EXP_WIDTH-1:0]  o_exp_c,
    output logic [FRAC_WIDTH-1:0] o_frac_c,
    output logic                  o_ovf,
    output logic                  o_unf,
    output logic [TAG_WIDTH-1:0]  o_tag
);
    // aligned fraction carries two guard bits; the sum adds one carry bit
    localparam int AW  = FRAC_WIDTH + 2;
    localparam int SW  = FRAC_WIDTH + 3;
    localparam int DW  = EXP_WIDTH + 1;
    localparam int XW  = EXP_WIDTH + 2;
    localparam int LZW = $clog2(AW);

    localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** (EXP_WIDTH - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MIN = XW'(-(2 ** (EXP_WIDTH - 1)));

    // handshake: one global stall freezes every stage
    logic w_stall;
    logic w_adv;

    // stage 1 (align) combinational
    logic                  w_sign_b_eff;
    logic signed [DW-1:0]  w_exp_diff;
    logic                  w_a_large;
    logic [DW-1:0]         w_shift;
    logic                  w_sign_l;
    logic                  w_sign_s;
    logic [EXP_WIDTH-1:0]  w_exp_l;
    logic [FRAC_WIDTH-1:0] w_frac_l;
    logic [FRAC_WIDTH-1:0] w_frac_s;
    logic [AW-1:0]         w_small_al;

    // stage 1 registers
    logic                  r1_valid;
    logic                  r1_sign;
    logic                  r1_sub;
    logic [EXP_WIDTH-1:0]  r1_exp;
    logic [AW-1:0]         r1_frac_l;
    logic [AW-1:0]         r1_frac_s;
    logic [TAG_WIDTH-1:0]  r1_tag;

    // stage 2 (add)
    logic [SW-1:0]         w_sum;
    logic                  r2_valid;
    logic                  r2_sign;
    logic [EXP_WIDTH-1:0]  r2_exp;
    logic [SW-1:0]         r2_sum;
    logic [TAG_WIDTH-1:0]  r2_tag;

    // stage 3 (normalise)
    logic [LZW-1:0]        w_lzc;
    logic [AW-1:0]         w_shl;
    logic signed [XW-1:0]  w_exp_ext;
    logic signed [XW-1:0]  w_norm_exp;
    logic [FRAC_WIDTH-1:0] w_norm_frac;
    logic                  w_norm_zero;
    logic                  w_unused;
    logic                  r3_valid;
    logic                  r3_sign;
    logic                  r3_zero;
    logic signed [XW-1:0]  r3_exp;
    logic [FRAC_WIDTH-1:0] r3_frac;
    logic [TAG_WIDTH-1:0]  r3_tag;

    // output stage (range check)
    logic                  w_out_sign;
    logic [EXP_WIDTH-1:0]  w_out_exp;
    logic [FRAC_WIDTH-1:0] w_out_frac;
    logic                  w_out_ovf;
    logic                  w_out_unf;
    logic                  r_out_valid;
    logic                  r_out_sign;
    logic [EXP_WIDTH-1:0]  r_out_exp;
    logic [FRAC_WIDTH-1:0] r_out_frac;
    logic                  r_out_ovf;
    logic                  r_out_unf;
    logic [TAG_WIDTH-1:0]  r_out_tag;

    assign w_stall = r_out_valid & ~i_ready;
    assign w_adv   = ~w_stall;
    assign o_ready = w_adv;

    assign w_sign_b_eff = i_sign_b ^ i_op;
    assign w_exp_diff   = $signed({i_exp_a[EXP_WIDTH-1], i_exp_a})
                        - $signed({i_exp_b[EXP_WIDTH-1], i_exp_b});

    // pick the large operand (zero never wins) and right-align the small one
    always_comb begin
        w_a_large = (i_frac_b == '0)
                 || ((i_frac_a != '0)
                     && ((!w_exp_diff[DW-1] && (w_exp_diff != '0))
                         || ((w_exp_diff == '0) && (i_frac_a >= i_frac_b))));
        if (w_a_large) begin
            w_sign_l = i_sign_a;
            w_sign_s = w_sign_b_eff;
            w_exp_l  = i_exp_a;
            w_frac_l = i_frac_a;
            w_frac_s = i_frac_b;
            w_shift  = w_exp_diff;
        end else begin
            w_sign_l = w_sign_b_eff;
            w_sign_s = i_sign_a;
            w_exp_l  = i_exp_b;
            w_frac_l = i_frac_b;
            w_frac_s = i_frac_a;
            w_shift  = -w_exp_diff;
        end
        // a zero small operand aligns to zero whatever the shift amount is
        w_small_al = (w_shift >= DW'(AW)) ? '0 : ({w_frac_s, 2'b00} >> w_shift);
    end

    // stage 1 register: aligned operands
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r1_valid  <= 1'b0;
            r1_sign   <= 1'b0;
            r1_sub    <= 1'b0;
            r1_exp    <= '0;
            r1_frac_l <= '0;
            r1_frac_s <= '0;
            r1_tag    <= '0;
        end else if (w_adv) begin
            r1_valid  <= i_valid;
            r1_sign   <= w_sign_l;
            r1_sub    <= w_sign_l ^ w_sign_s;
            r1_exp    <= w_exp_l;
            r1_frac_l <= {w_frac_l, 2'b00};
            r1_frac_s <= w_small_al;
            r1_tag    <= i_tag;
        end
    end

    // the swap guarantees large >= small, so the difference never goes negative
    assign w_sum = r1_sub ? ({1'b0, r1_frac_l} - {1'b0, r1_frac_s})
                          : ({1'b0, r1_frac_l} + {1'b0, r1_frac_s});

    // stage 2 register: magnitude sum
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r2_valid <= 1'b0;
            r2_sign  <= 1'b0;
            r2_exp   <= '0;
            r2_sum   <= '0;
            r2_tag   <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_sign  <= r1_sign;
            r2_exp   <= r1_exp;
            r2_sum   <= w_sum;
            r2_tag   <= r1_tag;
        end
    end

    assign w_exp_ext   = {{2{r2_exp[EXP_WIDTH-1]}}, r2_exp};
    assign w_norm_zero = (r2_sum == '0);

    // leading-zero count below the carry bit, then shift and drop guard bits
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < AW; i++) begin
            if (r2_sum[i]) begin
                w_lzc = LZW'(AW - 1 - i);
            end
        end
        w_shl = r2_sum[AW-1:0] << w_lzc;
        if (r2_sum[SW-1]) begin
            w_norm_frac = r2_sum[SW-1:3];
            w_norm_exp  = w_exp_ext + XW'(1);
        end else begin
            w_norm_frac = w_shl[AW-1:2];
            w_norm_exp  = w_exp_ext - XW'(w_lzc);
        end
    end

    assign w_unused = ^w_shl[1:0];

    // stage 3 register: normalised fraction with widened exponent
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r3_valid <= 1'b0;
            r3_sign  <= 1'b0;
            r3_zero  <= 1'b0;
            r3_exp   <= '0;
            r3_frac  <= '0;
            r3_tag   <= '0;
        end else if (w_adv) begin
            r3_valid <= r2_valid;
            r3_sign  <= r2_sign;
            r3_zero  <= w_norm_zero;
            r3_exp   <= w_norm_exp;
            r3_frac  <= w_norm_frac;
            r3_tag   <= r2_tag;
        end
    end

    // exponent range check: saturate on overflow, flush to +0 on underflow
    always_comb begin
        w_out_sign = r3_sign;
        w_out_exp  = r3_exp[EXP_WIDTH-1:0];
        w_out_frac = r3_frac;
        w_out_ovf  = 1'b0;
        w_out_unf  = 1'b0;
        if (r3_zero) begin
            w_out_sign = 1'b0;
            w_out_exp  = '0;
            w_out_frac = '0;
        end else if (r3_exp > EXP_MAX) begin
            w_out_ovf  = 1'b1;
            w_out_exp  = EXP_MAX[EXP_WIDTH-1:0];
            w_out_frac = '1;
        end else if (r3_exp < EXP_MIN) begin
            w_out_unf  = 1'b1;
            w_out_sign = 1'b0;
            w_out_exp  = '0;
            w_out_frac = '0;
        end
    end

    // output register: holds steady while the consumer stalls
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_frac  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_adv) begin
            r_out_valid <= r3_valid;
            r_out_sign  <= w_out_sign;
            r_out_exp   <= w_out_exp;
            r_out_frac  <= w_out_frac;
            r_out_ovf   <= w_out_ovf;
            r_out_unf   <= w_out_unf;
            r_out_tag   <= r3_tag;
        end
    end

    assign o_valid  = r_out_valid;
    assign o_sign_c = r_out_sign;
    assign o_exp_c  = r_out_exp;
    assign o_frac_c = r_out_frac;
    assign o_ovf    = r_out_ovf;
    assign o_unf    = r_out_unf;
    assign o_tag    = r_out_tag;

endmodule

// File: tb/tb_fadd_pipe_n.sv
// tb/tb_fadd_pipe_n.sv - scoreboard bench for fadd_pipe_n
module tb_fadd_pipe_n;
    localparam int FW    = 36;
    localparam int EW    = 8;
    localparam int TW    = 4;
    localparam int GW    = FW + 2;
    localparam int EMAXV = (1 << (EW - 1)) - 1;
    localparam int EMINV = -(1 << (EW - 1));

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [FW-1:0] frac;
        logic          ovf;
        logic          unf;
        logic [TW-1:0] tag;
    } res_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_op = 1'b0;
    logic          i_sign_a = 1'b0;
    logic          i_sign_b = 1'b0;
    logic [EW-1:0] i_exp_a = '0;
    logic [EW-1:0] i_exp_b = '0;
    logic [FW-1:0] i_frac_a = '0;
    logic [FW-1:0] i_frac_b = '0;
    logic [TW-1:0] i_tag = '0;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          o_sign_c;
    logic [EW-1:0] o_exp_c;
    logic [FW-1:0] o_frac_c;
    logic          o_ovf;
    logic          o_unf;
    logic [TW-1:0] o_tag;

    res_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   rdy_rand = 1'b0;
    int   stall_lo = -1;
    int   stall_hi = -2;

    fadd_pipe_n #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW), .TAG_WIDTH(TW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_sign_a(i_sign_a), .i_sign_b(i_sign_b),
        .i_exp_a(i_exp_a), .i_exp_b(i_exp_b), .i_frac_a(i_frac_a), .i_frac_b(i_frac_b),
        .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready), .o_sign_c(o_sign_c),
        .o_exp_c(o_exp_c), .o_frac_c(o_frac_c), .o_ovf(o_ovf), .o_unf(o_unf), .o_tag(o_tag)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (cyc >= stall_lo && cyc <= stall_hi) i_ready = 1'b0;
        else if (rdy_rand)                      i_ready = ($urandom_range(0, 3) != 0);
        else                                    i_ready = 1'b1;
    end

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // value = frac * 2^(exp-FW+1); align with two guard bits, truncate, renormalise
    function automatic res_t model(input bit op, input bit sa, input bit sb,
                                   input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                                   input logic [FW-1:0] fa, input logic [FW-1:0] fb,
                                   input logic [TW-1:0] tag);
        res_t r;
        bit sbe, a_big, sl, ss;
        int xa, xb, el, es, d, e;
        longint unsigned ml, ms, sm, mag;
        r = '0;
        r.tag = tag;
        sbe = sb ^ op;
        xa = int'($signed(ea));
        xb = int'($signed(eb));
        if (fa == 0 && fb == 0) return r;
        a_big = (fb == 0) || (fa != 0 && (xa > xb || (xa == xb && fa >= fb)));
        if (a_big) begin ml = fa; ms = fb; el = xa; es = xb; sl = sa;  ss = sbe; end
        else       begin ml = fb; ms = fa; el = xb; es = xa; sl = sbe; ss = sa;  end
        d = el - es;
        if (ms == 0 || d >= GW) sm = 0;
        else                    sm = (ms << 2) >> d;
        ml = ml << 2;
        mag = (sl == ss) ? ml + sm : ml - sm;
        if (mag == 0) return r;
        e = el;
        while (mag >= (64'd1 << GW))       begin mag = mag >> 1; e++; end
        while (mag <  (64'd1 << (GW - 1))) begin mag = mag << 1; e--; end
        if (e > EMAXV) begin
            r.sign = sl; r.exp = EW'(EMAXV); r.frac = '1; r.ovf = 1'b1;
        end else if (e < EMINV) begin
            r.unf = 1'b1;
        end else begin
            r.sign = sl; r.exp = EW'(e); r.frac = FW'(mag >> 2);
        end
        return r;
    endfunction

    function automatic res_t mk(input bit s, input logic [EW-1:0] e, input logic [FW-1:0] f,
                                input bit ov, input bit un);
        res_t r;
        r = '0;
        r.sign = s; r.exp = e; r.frac = f; r.ovf = ov; r.unf = un;
        return r;
    endfunction

    task automatic wait_neg();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic send(input bit op, input bit sa, input bit sb,
                        input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                        input logic [FW-1:0] fa, input logic [FW-1:0] fb,
                        input logic [TW-1:0] tag, input bit use_fixed, input res_t fixed);
        res_t e;
        bit acc;
        int tries;
        e = use_fixed ? fixed : model(op, sa, sb, ea, eb, fa, fb, tag);
        e.tag = tag;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = op; i_sign_a = sa; i_sign_b = sb;
        i_exp_a = ea; i_exp_b = eb; i_frac_a = fa; i_frac_b = fb; i_tag = tag;
        acc = 1'b0;
        tries = 0;
        while (!acc) begin
            #2;
            acc = o_ready;
            @(posedge i_clk);
            if (acc) sbq.push_back(e);
            else begin
                tries++;
                if (tries > 200) begin
                    n_cmp++; n_bad++;
                    $display("FAIL accept_timeout: got o_ready=0 for %0d cycles expected acceptance", tries);
                    summary();
                    $fatal(1, "accept timeout");
                end
                @(negedge i_clk);
            end
        end
    endtask

    task automatic rand_op(input logic [TW-1:0] tag);
        logic [63:0]   r;
        bit            op, sa, sb;
        logic [EW-1:0] ea, eb;
        logic [FW-1:0] fa, fb;
        int            m;
        r = {$urandom, $urandom}; fa = r[FW-1:0]; fa[FW-1] = 1'b1;
        r = {$urandom, $urandom}; fb = r[FW-1:0]; fb[FW-1] = 1'b1;
        ea = EW'($urandom);
        eb = EW'($urandom);
        op = 1'($urandom_range(0, 1));
        sa = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        m = $urandom_range(0, 7);
        case (m)
            1, 2, 3: eb = ea + EW'($urandom_range(0, 4)) - EW'(2);
            4: begin ea = ($urandom_range(0, 1) != 0) ? EW'(EMAXV) : EW'(EMINV); eb = ea; end
            5: begin eb = ea; fb = ($urandom_range(0, 3) == 0) ? fa : (fa ^ FW'($urandom_range(0, 255))); end
            6: if ($urandom_range(0, 1) != 0) fa = '0; else fb = '0;
            7: eb = ea - EW'($urandom_range(34, 40));
            default: ;
        endcase
        send(op, sa, sb, ea, eb, fa, fb, tag, 1'b0, '0);
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        sbq.delete();
        @(negedge i_clk);
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_outputs", {o_sign_c, o_exp_c, o_frac_c, o_ovf, o_unf, o_tag}, 0);
        check("rst_o_ready", o_ready, 1);
        i_rst_n = 1'b1;
    endtask

    task automatic measure_latency(input string name);
        int k;
        for (k = 1; k <= 10; k++) begin
            wait_neg();
            #1;
            if (o_valid) break;
        end
        check(name, k, 4);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sbq.size() != 0; k++) wait_neg();
        check("drain_empty", sbq.size(), 0);
        repeat (5) wait_neg();
    endtask

    // monitor: compares each handed-over result and checks hold-under-stall
    initial begin
        res_t cur, held;
        bit   held_ok;
        held_ok = 1'b0;
        held = '0;
        forever begin
            @(negedge i_clk);
            #2;
            cur = {o_sign_c, o_exp_c, o_frac_c, o_ovf, o_unf, o_tag};
            if (!i_rst_n) begin
                held_ok = 1'b0;
            end else begin
                check("o_ready", o_ready, !(o_valid && !i_ready));
                if (held_ok) begin
                    check("stall_hold_valid", o_valid, 1);
                    check("stall_hold_data", cur, held);
                end
                if (o_valid) begin
                    if (i_ready) begin
                        if (sbq.size() == 0) begin
                            n_cmp++; n_bad++;
                            $display("FAIL unexpected_result: got %h expected no result", cur);
                        end else begin
                            check("result", cur, sbq.pop_front());
                        end
                        held_ok = 1'b0;
                    end else begin
                        held = cur;
                        held_ok = 1'b1;
                    end
                end else begin
                    held_ok = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge i_clk);
        apply_reset();

        send(0, 0, 0, 8'd0, 8'd0, 36'h8_0000_0000, 36'h8_0000_0000, 4'h1, 1, mk(0, 8'd1, 36'h8_0000_0000, 0, 0));
        measure_latency("latency_first");
        send(1, 0, 0, 8'd0, 8'd0, 36'hC_0000_0000, 36'h8_0000_0000, 4'h2, 1, mk(0, 8'hFF, 36'h8_0000_0000, 0, 0));
        send(1, 0, 0, 8'd0, 8'd0, 36'h8_0000_0000, 36'h8_0000_0000, 4'h3, 1, mk(0, 8'h00, 36'h0, 0, 0));
        send(0, 0, 0, 8'd0, 8'hD8, 36'h8_0000_0000, 36'h8_0000_0000, 4'h4, 1, mk(0, 8'h00, 36'h8_0000_0000, 0, 0));
        send(0, 0, 0, 8'd127, 8'd127, 36'h8_0000_0000, 36'h8_0000_0000, 4'h5, 1, mk(0, 8'h7F, 36'hF_FFFF_FFFF, 1, 0));
        send(1, 0, 0, 8'h80, 8'h80, 36'hC_0000_0000, 36'h8_0000_0000, 4'h6, 1, mk(0, 8'h00, 36'h0, 0, 1));
        send(1, 0, 1, 8'd7, 8'd5, 36'h0, 36'hA_0000_0000, 4'h7, 1, mk(0, 8'd5, 36'hA_0000_0000, 0, 0));
        send(0, 1, 1, 8'd3, 8'd9, 36'h0, 36'h0, 4'h8, 1, mk(0, 8'h00, 36'h0, 0, 0));
        send(1, 0, 0, 8'd0, 8'd0, 36'h8_0000_0000, 36'hC_0000_0000, 4'h9, 1, mk(1, 8'hFF, 36'h8_0000_0000, 0, 0));
        send(0, 0, 0, 8'd1, 8'd0, 36'h8_0000_0000, 36'h8_0000_0000, 4'hA, 1, mk(0, 8'd1, 36'hC_0000_0000, 0, 0));
        send(1, 0, 0, 8'd0, 8'hDB, 36'h8_0000_0000, 36'h8_0000_0000, 4'hB, 1, mk(0, 8'hFF, 36'hF_FFFF_FFFF, 0, 0));
        send(1, 0, 0, 8'd0, 8'hDA, 36'h8_0000_0000, 36'h8_0000_0000, 4'hC, 1, mk(0, 8'h00, 36'h8_0000_0000, 0, 0));
        drain();

        base = cyc;
        stall_lo = base + 5;
        stall_hi = base + 7;
        for (int t = 0; t < 8; t++) rand_op(TW'(t));
        drain();
        stall_lo = -1;
        stall_hi = -2;

        rdy_rand = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rand_op(TW'(n));
            if ($urandom_range(0, 3) == 0) wait_neg();
        end
        drain();
        rdy_rand = 1'b0;
        repeat (2) wait_neg();

        for (int t = 0; t < 3; t++) rand_op(TW'(t + 10));
        apply_reset();
        repeat (8) wait_neg();
        send(0, 0, 0, 8'd2, 8'd2, 36'h9_0000_0000, 36'h9_0000_0000, 4'hE, 1, mk(0, 8'd3, 36'h9_0000_0000, 0, 0));
        measure_latency("latency_after_reset");
        drain();

        summary();
        $finish;
    end
endmodule
